// File: rtl/gpu_dual_port_ram_pipe.sv
// gpu_dual_port_ram_pipe
// Single-clock GPU RAM with two ports:
//  - Port A: GPU read channel. Its addr/cmd/pc_ena sideband travels through a
//    PIPE_DELAY-deep delay line, so it stays aligned with the read data.
//  - Port B: host read/write port with a req/ack handshake, range checking and
//    a busy flag.
// Every read is read-before-write. A port-A read issued in the same cycle as a
// host write to the same word returns the old contents.

module gpu_dual_port_ram_pipe #(
  parameter int ADDR_SIZE  = 14,
  parameter int NUM_WORDS  = 2**ADDR_SIZE,
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_DELAY = 2,
  parameter int CMD_WIDTH  = 16,
  parameter int PCE_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // Port A: GPU read channel
  input  logic                  rd_ena_a,
  input  logic [19:0]           addr_a,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [PCE_WIDTH-1:0]  pc_ena_in,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [19:0]           addr_out_a,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic [PCE_WIDTH-1:0]  pc_ena_out,
  // Port B: host channel
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [19:0]           host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic                  host_oor,
  output logic                  host_busy
);

  localparam logic [19:0] LIMIT       = 20'(NUM_WORDS);
  localparam int          DATA_STAGES = PIPE_DELAY - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } host_state_t;

  // Address range helper shared by both ports
  function automatic logic in_range(input logic [19:0] addr);
    return (addr < LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Port A read path
  logic                  rd_ena_q;
  logic                  rd_oor_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] ram_out_q;

  // Host path
  host_state_t           state_q, state_d;
  logic                  wr_commit_s;
  logic                  ack_d;
  logic                  acc_oor_q, acc_oor_d;
  logic                  host_in_range_s;
  logic [DATA_WIDTH-1:0] host_word_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic                  host_ack_q;
  logic                  host_oor_q;
  logic                  host_busy_q;

  assign host_in_range_s = in_range(host_addr);

  // RAM array: host write port plus the two read-before-write read registers
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_q[host_addr[ADDR_SIZE-1:0]] <= host_wdata;
    end
    rd_word_q   <= mem_q[addr_a[ADDR_SIZE-1:0]];
    host_word_q <= mem_q[host_addr[ADDR_SIZE-1:0]];
  end

  // Port A: capture strobe and range, then update the RAM output register only on a strobed read
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ena_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      ram_out_q <= '0;
    end else begin
      rd_ena_q <= rd_ena_a;
      rd_oor_q <= ~in_range(addr_a);
      if (rd_ena_q) begin
        ram_out_q <= rd_oor_q ? '0 : rd_word_q;
      end
    end
  end

  // Extra data stages, so that data lines up with the PIPE_DELAY-deep sideband
  generate
    if (DATA_STAGES == 0) begin : g_no_extra
      assign data_out_a = ram_out_q;
    end else begin : g_extra
      logic [DATA_WIDTH-1:0] dly_q [DATA_STAGES];

      // Data delay line
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DATA_STAGES; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= ram_out_q;
          for (int i = 1; i < DATA_STAGES; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign data_out_a = dly_q[DATA_STAGES-1];
    end
  endgenerate

  logic [19:0]          addr_pipe_q [PIPE_DELAY];
  logic [CMD_WIDTH-1:0] cmd_pipe_q  [PIPE_DELAY];
  logic [PCE_WIDTH-1:0] pce_pipe_q  [PIPE_DELAY];

  // Sideband delay line: advances every cycle whatever the value of rd_ena_a
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        addr_pipe_q[i] <= 20'd0;
        cmd_pipe_q[i]  <= '0;
        pce_pipe_q[i]  <= '0;
      end
    end else begin
      addr_pipe_q[0] <= addr_a;
      cmd_pipe_q[0]  <= cmd_in;
      pce_pipe_q[0]  <= pc_ena_in;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        addr_pipe_q[i] <= addr_pipe_q[i-1];
        cmd_pipe_q[i]  <= cmd_pipe_q[i-1];
        pce_pipe_q[i]  <= pce_pipe_q[i-1];
      end
    end
  end

  assign addr_out_a = addr_pipe_q[PIPE_DELAY-1];
  assign cmd_out    = cmd_pipe_q[PIPE_DELAY-1];
  assign pc_ena_out = pce_pipe_q[PIPE_DELAY-1];

  // Host FSM next-state: requests are sampled only in IDLE; a write commits on its accept edge
  always_comb begin
    state_d     = state_q;
    wr_commit_s = 1'b0;
    acc_oor_d   = acc_oor_q;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          acc_oor_d = ~host_in_range_s;
          if (host_wr) begin
            state_d     = WR_ACK;
            wr_commit_s = host_in_range_s & ~reset;
          end else begin
            state_d = RD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACK:  state_d = IDLE;
      RD_WAIT: state_d = RD_ACK;
      RD_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == WR_ACK) || (state_d == RD_ACK);
  end

  // Host FSM state and registered handshake outputs; read data is latched on entry to RD_ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_oor_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_oor_q   <= 1'b0;
      host_busy_q  <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_oor_q   <= acc_oor_d;
      host_ack_q  <= ack_d;
      host_oor_q  <= ack_d & acc_oor_d;
      host_busy_q <= (state_d != IDLE);
      if (state_q == RD_WAIT) begin
        host_rdata_q <= acc_oor_q ? '0 : host_word_q;
      end
    end
  end

  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_oor   = host_oor_q;
  assign host_busy  = host_busy_q;

endmodule

// File: tb/tb_gpu_dual_port_ram_pipe.sv
// Scoreboard bench for gpu_dual_port_ram_pipe. The design is built with
// PIPE_DELAY=4 and NUM_WORDS=12000. Stimulus pushes expected host acks and
// port-A results, each tagged with the cycle it is due in. A monitor process
// pops and compares those entries at every falling edge.

module tb_gpu_dual_port_ram_pipe;

  localparam int PD = 4;
  localparam int NW = 12000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_ena_a;
  logic [19:0] addr_a;
  logic [15:0] cmd_in;
  logic [3:0]  pc_ena_in;
  logic [7:0]  data_out_a;
  logic [19:0] addr_out_a;
  logic [15:0] cmd_out;
  logic [3:0]  pc_ena_out;
  logic        host_req;
  logic        host_wr;
  logic [19:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_ack;
  logic        host_oor;
  logic        host_busy;

  gpu_dual_port_ram_pipe #(
    .ADDR_SIZE(14), .NUM_WORDS(NW), .DATA_WIDTH(8),
    .PIPE_DELAY(PD), .CMD_WIDTH(16), .PCE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_ena_a(rd_ena_a), .addr_a(addr_a), .cmd_in(cmd_in), .pc_ena_in(pc_ena_in),
    .data_out_a(data_out_a), .addr_out_a(addr_out_a), .cmd_out(cmd_out), .pc_ena_out(pc_ena_out),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_oor(host_oor), .host_busy(host_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       chk_data;
    logic [7:0] data;
    logic       oor;
  } host_exp_t;

  typedef struct {
    int          due;
    logic [7:0]  data;
    logic [19:0] addr;
    logic [15:0] cmd;
    logic [3:0]  pce;
  } pa_exp_t;

  host_exp_t hq[$];
  pa_exp_t   pq[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares host acks and due port-A results against the queues
  always @(negedge clk) begin
    host_exp_t he;
    pa_exp_t   pe;
    if (host_ack === 1'b1) begin
      if (hq.size() == 0) begin
        chk("unexpected_host_ack", 32'd1, 32'd0);
      end else begin
        he = hq.pop_front();
        chk("host_ack_cycle", cyc, he.due);
        chk("host_oor", {31'd0, host_oor}, {31'd0, he.oor});
        if (he.chk_data) chk("host_rdata", {24'd0, host_rdata}, {24'd0, he.data});
      end
    end else if (hq.size() > 0 && hq[0].due < cyc) begin
      he = hq.pop_front();
      chk("host_ack_timeout", 32'd0, 32'd1);
    end
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      pe = pq.pop_front();
      chk("pa_cycle", cyc, pe.due);
      chk("pa_data", {24'd0, data_out_a}, {24'd0, pe.data});
      chk("pa_addr", {12'd0, addr_out_a}, {12'd0, pe.addr});
      chk("pa_cmd", {16'd0, cmd_out}, {16'd0, pe.cmd});
      chk("pa_pce", {28'd0, pc_ena_out}, {28'd0, pe.pce});
    end
  end

  task automatic push_host(input int lat, input logic cd, input logic [7:0] d, input logic o);
    host_exp_t e;
    e.due = cyc + lat; e.chk_data = cd; e.data = d; e.oor = o;
    hq.push_back(e);
  endtask

  task automatic host_write(input logic [19:0] a, input logic [7:0] d, input logic o);
    host_req = 1'b1; host_wr = 1'b1; host_addr = a; host_wdata = d;
    push_host(1, 1'b0, 8'h00, o);
    tick();
    host_req = 1'b0;
    tick();
  endtask

  task automatic host_read(input logic [19:0] a, input logic [7:0] d, input logic o);
    host_req = 1'b1; host_wr = 1'b0; host_addr = a;
    push_host(2, 1'b1, d, o);
    tick();
    host_req = 1'b0;
    tick();
    tick();
  endtask

  // Drives port A for the current cycle and records what must emerge PD cycles later
  task automatic pa_drive(input logic en, input logic [19:0] a, input logic [15:0] c,
                          input logic [3:0] p, input logic [7:0] d);
    pa_exp_t e;
    rd_ena_a = en; addr_a = a; cmd_in = c; pc_ena_in = p;
    e.due = cyc + PD; e.data = d; e.addr = a; e.cmd = c; e.pce = p;
    pq.push_back(e);
  endtask

  task automatic pa_idle();
    rd_ena_a = 1'b0; addr_a = 20'd0; cmd_in = 16'd0; pc_ena_in = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_data_out_a"}, {24'd0, data_out_a}, 32'd0);
    chk({tag, "_addr_out_a"}, {12'd0, addr_out_a}, 32'd0);
    chk({tag, "_cmd_out"}, {16'd0, cmd_out}, 32'd0);
    chk({tag, "_pc_ena_out"}, {28'd0, pc_ena_out}, 32'd0);
    chk({tag, "_host_rdata"}, {24'd0, host_rdata}, 32'd0);
    chk({tag, "_host_ack"}, {31'd0, host_ack}, 32'd0);
    chk({tag, "_host_oor"}, {31'd0, host_oor}, 32'd0);
    chk({tag, "_host_busy"}, {31'd0, host_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b1; host_req = 1'b0; host_wr = 1'b0; host_addr = 20'd0; host_wdata = 8'd0;
    pa_idle();
    tick(); tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");
    tick();

    // Host write then read back
    host_write(20'h00010, 8'hA5, 1'b0);
    host_read(20'h00010, 8'hA5, 1'b0);

    // Port-A read with sideband; next cycle no strobe, so data holds while sideband moves on
    pa_drive(1'b1, 20'h00010, 16'h1234, 4'b0101, 8'hA5);
    tick();
    pa_drive(1'b0, 20'h00020, 16'hBEEF, 4'b1010, 8'hA5);
    tick();
    pa_idle();
    repeat (PD) tick();

    // Collision: same-cycle host write and port-A read return old data
    host_write(20'h00020, 8'h00, 1'b0);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 20'h00020; host_wdata = 8'h3C;
    push_host(1, 1'b0, 8'h00, 1'b0);
    pa_drive(1'b1, 20'h00020, 16'h0001, 4'b0001, 8'h00);
    tick();
    host_req = 1'b0;
    pa_drive(1'b1, 20'h00020, 16'h0002, 4'b0010, 8'h3C);
    tick();
    pa_idle();
    repeat (PD) tick();
    host_read(20'h00020, 8'h3C, 1'b0);

    // Range boundaries
    host_write(20'd12000, 8'hEE, 1'b1);
    host_read(20'd12000, 8'h00, 1'b1);
    host_write(20'd11999, 8'h5A, 1'b0);
    host_read(20'd11999, 8'h5A, 1'b0);
    pa_drive(1'b1, 20'd12000, 16'h0BAD, 4'b1111, 8'h00);
    tick();
    pa_drive(1'b1, 20'd11999, 16'h0C0D, 4'b0011, 8'h5A);
    tick();
    pa_drive(1'b1, 20'h40010, 16'h0E0F, 4'b1100, 8'h00);
    tick();
    pa_idle();
    repeat (PD) tick();
    host_read(20'h00010, 8'hA5, 1'b0);

    // Held read request: one ack per 3 cycles, busy 0,1,1
    start = cyc;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00020;
    for (int k = 0; k < 4; k++) begin
      host_exp_t e;
      e.due = start + 2 + 3 * k; e.chk_data = 1'b1; e.data = 8'h3C; e.oor = 1'b0;
      hq.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_pattern", {31'd0, host_busy}, {31'd0, ((i % 3) != 0)});
      tick();
    end
    host_req = 1'b0;
    repeat (4) tick();

    // Request during reset is dropped
    host_write(20'h00030, 8'h11, 1'b0);
    reset = 1'b1; host_req = 1'b1; host_wr = 1'b1; host_addr = 20'h00030; host_wdata = 8'h77;
    tick();
    reset = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk("busy_after_reset_req", {31'd0, host_busy}, 32'd0);
    tick();
    host_read(20'h00030, 8'h11, 1'b0);

    // Reset while in RD_WAIT: no ack, all outputs cleared, RAM intact
    host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00010;
    tick();
    host_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("busy_in_rd_wait", {31'd0, host_busy}, 32'd1);
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    tick();
    host_read(20'h00010, 8'hA5, 1'b0);

    repeat (6) tick();
    chk("host_queue_drained", hq.size(), 32'd0);
    chk("pa_queue_drained", pq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
